// File: rtl/pulse_period_monitor.sv
// Measures the edge-to-edge interval of a periodic pulse and checks it
// against an expected period; reports lock, short/missing-pulse errors.
module pulse_period_monitor #(
    parameter int EXP_PERIOD = 100001,
    parameter int TOL        = 16,
    parameter int LOCK_N     = 4,
    parameter int CNT_W      = 18
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PULSE_IN,
    input  logic             CLEAR_STATS,
    output logic [CNT_W-1:0] PERIOD,
    output logic             PERIOD_VALID,
    output logic             LOCKED,
    output logic             ERR_SHORT,
    output logic             ERR_LONG,
    output logic [15:0]      ERR_COUNT
);

    typedef enum logic {
        WAIT_FIRST,
        TRACK
    } state_t;

    localparam logic [CNT_W-1:0] SHORT_LIM = CNT_W'(EXP_PERIOD - TOL);
    localparam logic [CNT_W-1:0] TO_LIM    = CNT_W'(EXP_PERIOD + TOL + 1);
    localparam logic [3:0]       LOCK_V    = 4'(LOCK_N);

    state_t           state_q, state_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             locked_q, locked_d;
    logic             err_short_q, err_short_d;
    logic             err_long_q, err_long_d;
    logic [15:0]      err_count_q, err_count_d;
    logic [3:0]       good_q, good_d;
    logic             edge_w;

    always_comb begin
        edge_w         = PULSE_IN & ~prev_q;
        prev_d         = PULSE_IN;
        state_d        = state_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        err_short_d    = 1'b0;
        err_long_d     = 1'b0;
        good_d         = good_q;
        locked_d       = locked_q;

        if (edge_w) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == '1) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            WAIT_FIRST: begin
                if (edge_w) begin
                    state_d = TRACK;
                end
            end
            TRACK: begin
                // An edge arriving on the timeout cycle wins over the timeout.
                if (edge_w) begin
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    if (cnt_q < SHORT_LIM) begin
                        err_short_d = 1'b1;
                        good_d      = 4'd0;
                        locked_d    = 1'b0;
                    end else begin
                        if (good_q != LOCK_V) begin
                            good_d = good_q + 4'd1;
                        end
                        if (good_d == LOCK_V) begin
                            locked_d = 1'b1;
                        end
                    end
                end else if (cnt_q == TO_LIM) begin
                    err_long_d = 1'b1;
                    good_d     = 4'd0;
                    locked_d   = 1'b0;
                    state_d    = WAIT_FIRST;
                end
            end
        endcase

        if (CLEAR_STATS) begin
            err_count_d = 16'd0;
        end else if ((err_short_d | err_long_d) && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= WAIT_FIRST;
            prev_q         <= 1'b0;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            err_short_q    <= 1'b0;
            err_long_q     <= 1'b0;
            err_count_q    <= 16'd0;
            good_q         <= 4'd0;
        end else begin
            state_q        <= state_d;
            prev_q         <= prev_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            err_short_q    <= err_short_d;
            err_long_q     <= err_long_d;
            err_count_q    <= err_count_d;
            good_q         <= good_d;
        end
    end

    assign PERIOD       = period_q;
    assign PERIOD_VALID = period_valid_q;
    assign LOCKED       = locked_q;
    assign ERR_SHORT    = err_short_q;
    assign ERR_LONG     = err_long_q;
    assign ERR_COUNT    = err_count_q;

endmodule

// File: tb/tb_pulse_period_monitor.sv
// Bench for pulse_period_monitor: cycle-indexed reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_pulse_period_monitor;

    localparam int EXP_PERIOD = 100;
    localparam int TOL        = 2;
    localparam int LOCK_N     = 4;
    localparam int CNT_W      = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             pulse_in;
    logic             clear_stats;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             err_short;
    logic             err_long;
    logic [15:0]      err_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    pulse_period_monitor #(
        .EXP_PERIOD(EXP_PERIOD),
        .TOL(TOL),
        .LOCK_N(LOCK_N),
        .CNT_W(CNT_W)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .PULSE_IN(pulse_in),
        .CLEAR_STATS(clear_stats),
        .PERIOD(period),
        .PERIOD_VALID(period_valid),
        .LOCKED(locked),
        .ERR_SHORT(err_short),
        .ERR_LONG(err_long),
        .ERR_COUNT(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: remembers the absolute cycle of the last rising edge
    // and derives intervals, run of good periods and errors from that.
    int      cyc = 0;
    int      last_edge;
    bit      tracking;
    bit      m_prev;
    int      run;
    int      m_period, m_errs;
    bit      m_pv, m_locked, m_es, m_el;
    int      ivl;

    always @(posedge clk) begin
        m_pv = 0;
        m_es = 0;
        m_el = 0;
        if (rst) begin
            tracking = 0;
            m_prev   = 0;
            run      = 0;
            m_period = 0;
            m_errs   = 0;
            m_locked = 0;
        end else begin
            if (pulse_in && !m_prev) begin
                if (tracking) begin
                    ivl      = cyc - last_edge;
                    m_period = ivl;
                    m_pv     = 1;
                    if (ivl < EXP_PERIOD - TOL) begin
                        m_es     = 1;
                        run      = 0;
                        m_locked = 0;
                    end else begin
                        run++;
                        if (run >= LOCK_N) m_locked = 1;
                    end
                end
                tracking  = 1;
                last_edge = cyc;
            end else if (tracking && (cyc - last_edge == EXP_PERIOD + TOL + 1)) begin
                m_el     = 1;
                run      = 0;
                m_locked = 0;
                tracking = 0;
            end
            m_prev = pulse_in;
            if (clear_stats) m_errs = 0;
            else if ((m_es || m_el) && m_errs < 65535) m_errs++;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_period", 32'(period), 32'(m_period));
            chk("model_valid", 32'(period_valid), 32'(m_pv));
            chk("model_locked", 32'(locked), 32'(m_locked));
            chk("model_err_short", 32'(err_short), 32'(m_es));
            chk("model_err_long", 32'(err_long), 32'(m_el));
            chk("model_err_count", 32'(err_count), 32'(m_errs));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic low(input int n);
        pulse_in = 1'b0;
        repeat (n) step();
    endtask

    // Single-cycle high pulse; on return the strobe for that edge is visible.
    task automatic one_edge();
        pulse_in = 1'b1;
        step();
        pulse_in = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        pulse_in    = 1'b0;
        clear_stats = 1'b0;
        step();
        chk_en = 1;
        step();
        step();
        chk("rst_period", 32'(period), 0);
        chk("rst_valid", 32'(period_valid), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err_count", 32'(err_count), 0);
        rst = 1'b0;
        low(5);

        // Lock acquisition
        one_edge();
        chk("first_edge_no_valid", 32'(period_valid), 0);
        for (int i = 1; i <= 5; i++) begin
            low(99);
            one_edge();
            chk("lock_valid", 32'(period_valid), 1);
            chk("lock_period", 32'(period), 100);
            if (i == 3) chk("lock_not_yet", 32'(locked), 0);
            if (i == 4) chk("lock_rise", 32'(locked), 1);
        end
        chk("lock_err_count", 32'(err_count), 0);

        // Tolerance boundaries
        low(97);
        one_edge();
        chk("tol98_period", 32'(period), 98);
        chk("tol98_short", 32'(err_short), 0);
        low(101);
        one_edge();
        chk("tol102_period", 32'(period), 102);
        chk("tol102_locked", 32'(locked), 1);
        low(96);
        one_edge();
        chk("tol97_short", 32'(err_short), 1);
        chk("tol97_period", 32'(period), 97);
        chk("tol97_locked", 32'(locked), 0);
        chk("tol97_err_count", 32'(err_count), 1);

        // Relock, then missing pulse
        repeat (4) begin
            low(99);
            one_edge();
        end
        chk("relock", 32'(locked), 1);
        low(102);
        chk("timeout_early", 32'(err_long), 0);
        low(1);
        chk("timeout_strobe", 32'(err_long), 1);
        chk("timeout_locked", 32'(locked), 0);
        chk("timeout_err_count", 32'(err_count), 2);
        low(1);
        chk("timeout_one_cycle", 32'(err_long), 0);
        low(10);
        one_edge();
        chk("after_timeout_no_valid", 32'(period_valid), 0);

        // Edge exactly on the timeout cycle
        low(102);
        one_edge();
        chk("edge103_valid", 32'(period_valid), 1);
        chk("edge103_period", 32'(period), 103);
        chk("edge103_no_long", 32'(err_long), 0);
        chk("edge103_no_short", 32'(err_short), 0);

        // Held-high input
        low(99);
        repeat (3) begin
            pulse_in = 1'b1;
            step();
            chk("held_valid", 32'(period_valid), 1);
            chk("held_period", 32'(period), 100);
            repeat (49) step();
            low(50);
        end

        // Clear together with a short edge, then reset mid-interval
        one_edge();
        low(49);
        one_edge();
        chk("short50_err_count", 32'(err_count), 3);
        low(49);
        clear_stats = 1'b1;
        one_edge();
        clear_stats = 1'b0;
        chk("clear_short_strobe", 32'(err_short), 1);
        chk("clear_wins", 32'(err_count), 0);
        low(30);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_period", 32'(period), 0);
        chk("midrst_valid", 32'(period_valid), 0);
        chk("midrst_locked", 32'(locked), 0);
        chk("midrst_short", 32'(err_short), 0);
        chk("midrst_long", 32'(err_long), 0);
        chk("midrst_err_count", 32'(err_count), 0);
        low(80);
        one_edge();
        chk("post_rst_first_edge", 32'(period_valid), 0);
        low(99);
        one_edge();
        chk("post_rst_valid", 32'(period_valid), 1);
        chk("post_rst_period", 32'(period), 100);
        low(5);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_period_monitor.md
Name: pulse_period_monitor

Overview:
Receive-side companion to the 1 kHz pulse generator. Measures the interval in CLK cycles between rising edges of a periodic pulse and checks it against an expected period within a tolerance. Reports each measured period, a lock indication and error strobes, plus a saturating error count. Sits on the consumer side of any tick line, for self-check of tick generators and for qualifying tick-driven logic.

Parameters:
EXP_PERIOD, 100001, expected edge-to-edge interval in CLK cycles (generator counts 0..100000, so the period is 100001).
TOL, 16, allowed deviation in cycles, inclusive; must satisfy TOL < EXP_PERIOD.
LOCK_N, 4, consecutive in-tolerance periods required to assert LOCKED; range 1..15.
CNT_W, 18, interval counter width; must hold EXP_PERIOD+TOL+1.

Ports:
CLK  in  1  system clock
RST  in  1  reset; synchronous, active-high
PULSE_IN  in  1  monitored pulse; same clock domain; only rising edges are significant
CLEAR_STATS  in  1  synchronous clear of ERR_COUNT
PERIOD  out  CNT_W  last measured interval in cycles
PERIOD_VALID  out  1  one-cycle strobe; PERIOD updated
LOCKED  out  1  level; LOCK_N consecutive good periods seen, no error since
ERR_SHORT  out  1  one-cycle strobe; interval < EXP_PERIOD-TOL
ERR_LONG  out  1  one-cycle strobe; no edge by EXP_PERIOD+TOL+1 cycles (missing pulse)
ERR_COUNT  out  16  saturating count of ERR_SHORT plus ERR_LONG events

Behaviour:
- Reset: PERIOD=0, PERIOD_VALID=0, LOCKED=0, ERR_SHORT=0, ERR_LONG=0, ERR_COUNT=0, good count=0, prev-input register=0, state=WAIT_FIRST. RST mid-measurement abandons it; no strobes are issued.
- Edge detect: edge = PULSE_IN & ~prev; prev <= PULSE_IN every cycle. A PULSE_IN held high counts as one edge.
- Interval counter cnt: loaded with 1 on an edge, otherwise increments, saturating at all-ones. If edges occur at cycles t and t+P, cnt equals P when the second edge is sampled.
- FSM, 2 states:
  - WAIT_FIRST: cnt is not checked. On edge: load cnt=1 and go to TRACK. No PERIOD_VALID is produced for the first edge.
  - TRACK, on edge: PERIOD<=cnt and PERIOD_VALID=1 on the next cycle. Classify cnt:
    - cnt < EXP_PERIOD-TOL: ERR_SHORT=1, good count=0, LOCKED=0. Stay in TRACK.
    - Otherwise, good: good count += 1, saturating at LOCK_N. LOCKED=1 when the updated count equals LOCK_N.
    - In both cases reload cnt=1.
  - TRACK, no edge and cnt == EXP_PERIOD+TOL+1: ERR_LONG=1 for one cycle, good count=0, LOCKED=0, go to WAIT_FIRST. PERIOD is not updated.
  - An edge on the same cycle the timeout value is reached counts as the edge, not a timeout. Inclusive boundaries: EXP_PERIOD-TOL and EXP_PERIOD+TOL are good.
- Latency: all outputs are registered. Strobes appear exactly one cycle after the edge, or after the timeout cycle, and last one cycle.
- ERR_COUNT: +1 per ERR_SHORT or ERR_LONG event; holds at 0xFFFF. CLEAR_STATS sets it to 0. CLEAR_STATS together with an error event gives 0 (clear wins). CLEAR_STATS does not affect LOCKED, PERIOD or the FSM.
- LOCKED stays high across good periods. It clears only on an error or RST.

Test Plan:
(Sim params: EXP_PERIOD=100, TOL=2, LOCK_N=4, CNT_W=8.)
- Lock acquisition: edges every 100 cycles, 6 edges -> first edge gives no strobe; 5 PERIOD_VALID strobes with PERIOD=100; LOCKED rises 1 cycle after the 5th edge (4th good period); ERR_COUNT=0.
- Tolerance boundaries: intervals 98, 102, 97 -> 98 and 102 good, no error; 97 gives ERR_SHORT=1, PERIOD=97, LOCKED=0, ERR_COUNT=1.
- Missing pulse: lock, then stop edges -> ERR_LONG exactly 103 cycles after the last edge is sampled (cnt reaches 103); state WAIT_FIRST; the next edge gives no PERIOD_VALID; ERR_COUNT increments by 1.
- Edge on timeout cycle: interval of exactly 103 -> ERR_LONG is never asserted; PERIOD=103, PERIOD_VALID=1, no ERR_SHORT; the interval counts as good.
- Held-high input: PULSE_IN high for 50 cycles, rising every 100 -> one strobe per 100 cycles, PERIOD=100.
- Reset/clear: ERR_COUNT=3, then CLEAR_STATS in the same cycle as a short edge -> ERR_COUNT=0. Assert RST mid-interval -> all outputs 0 the next cycle and no strobe afterward until two edges are seen.
